// File: rtl/control_sequencer.sv
// Control sequencer: decodes the current instruction into the 21-bit control bundle and
// sequences the multi-cycle MEMCPY instruction as alternating LOAD/STORE phases.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (illegal-instruction trap and HALT state).
`timescale 1ns/1ps

`ifndef CONTROLS_SV_DEFS
`define CONTROLS_SV_DEFS
`define ALU_ADD    4'b0000
`define ALU_SLL    4'b0001
`define ALU_SLT    4'b0010
`define ALU_SLTU   4'b0011
`define ALU_XOR    4'b0100
`define ALU_SRL    4'b0101
`define ALU_OR     4'b0110
`define ALU_AND    4'b0111
`define ALU_SUB    4'b1000
`define ALU_SRA    4'b1101
`define ALU_PASSB  4'b1111
`define LS_BYTE    2'b00
`define LS_HALF    2'b01
`define LS_WORD    2'b10
`define BR_NONE    3'd0
`define BR_EQ      3'd1
`define BR_NE      3'd2
`define BR_LT      3'd3
`define BR_GE      3'd4
`define BR_LTU     3'd5
`define BR_GEU     3'd6
`define BR_JUMP    3'd7
`define WSRC_ALU   2'b00
`define WSRC_MEM   2'b01
`define WSRC_PC4   2'b10
`endif

module control_sequencer #(
    parameter int unsigned CTRL_SIZE     = 21,
    parameter int unsigned ALU_SEL_WIDTH = 4,
    parameter logic [6:0]  MC_OPCODE     = 7'b0001011
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instruction,
    input  logic                 ex_no_stay,
    output logic [CTRL_SIZE-1:0] ctrl_signals,
    output logic                 busy
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                 illegal
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

`ifdef CTRL_ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MC_LOAD  = 2'd1,
        ST_MC_STORE = 2'd2,
        ST_HALT     = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MC_LOAD  = 2'd1,
        ST_MC_STORE = 2'd2
    } state_t;
`endif

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_bits;

    assign opcode    = instruction[6:0];
    assign funct3    = instruction[14:12];
    assign funct7_b5 = instruction[30];
    // Register indices and immediates are consumed by the datapath, not here.
    assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

    logic                     write_en;
    logic [ALU_SEL_WIDTH-1:0] alu_sel;
    logic                     alu_b_sel;
    logic                     alu_a_sel;
    logic                     mem_write;
    logic                     mem_read;
    logic [1:0]               ls_type;
    logic                     load_unsigned;
    logic [1:0]               write_src_sel;
    logic [2:0]               branch_type;
    logic                     stay;
    logic                     memcpy_store;
    logic                     counter_en;
    logic                     counter_sel;
    logic                     do_load;
    logic                     do_store;
    logic [CTRL_SIZE-1:0]     ctrl_c;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    logic mc_bad;
    assign mc_bad = (funct3 != 3'b000) && (funct3 != 3'b010);
`endif

    // State (and trap flag) register; reset returns to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Next-state selection and control-field decode.
    always_comb begin
        state_d       = state_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_d     = illegal_q;
`endif
        write_en      = 1'b0;
        alu_sel       = `ALU_ADD;
        alu_b_sel     = 1'b0;
        alu_a_sel     = 1'b0;
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        ls_type       = `LS_BYTE;
        load_unsigned = 1'b0;
        write_src_sel = `WSRC_ALU;
        branch_type   = `BR_NONE;
        stay          = 1'b0;
        memcpy_store  = 1'b0;
        counter_en    = 1'b0;
        counter_sel   = 1'b0;
        do_load       = 1'b0;
        do_store      = 1'b0;

        case (state_q)
            ST_RUN: begin
                case (opcode)
                    OP_R: begin
                        write_en = 1'b1;
                        alu_sel  = {funct7_b5, funct3};
                    end
                    OP_IMM: begin
                        write_en  = 1'b1;
                        alu_b_sel = 1'b1;
                        alu_sel   = (funct3 == 3'b101) ? {funct7_b5, funct3} : {1'b0, funct3};
                    end
                    OP_LOAD: begin
                        write_en      = 1'b1;
                        mem_read      = 1'b1;
                        alu_b_sel     = 1'b1;
                        write_src_sel = `WSRC_MEM;
                        ls_type       = funct3[1:0];
                        load_unsigned = funct3[2];
                    end
                    OP_STORE: begin
                        mem_write = 1'b1;
                        alu_b_sel = 1'b1;
                        ls_type   = funct3[1:0];
                    end
                    OP_BRANCH: begin
                        alu_sel = `ALU_SUB;
                        case (funct3)
                            3'b000:  branch_type = `BR_EQ;
                            3'b001:  branch_type = `BR_NE;
                            3'b100:  branch_type = `BR_LT;
                            3'b101:  branch_type = `BR_GE;
                            3'b110:  branch_type = `BR_LTU;
                            3'b111:  branch_type = `BR_GEU;
                            default: branch_type = `BR_NONE;
                        endcase
                    end
                    OP_JAL, OP_JALR: begin
                        write_en      = 1'b1;
                        alu_a_sel     = (opcode == OP_JAL);
                        alu_b_sel     = 1'b1;
                        write_src_sel = `WSRC_PC4;
                        branch_type   = `BR_JUMP;
                    end
                    OP_LUI: begin
                        write_en  = 1'b1;
                        alu_b_sel = 1'b1;
                        alu_sel   = `ALU_PASSB;
                    end
                    OP_AUIPC: begin
                        write_en  = 1'b1;
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    MC_OPCODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        if (mc_bad) begin
                            illegal_d = 1'b1;
                            state_d   = ST_HALT;
                        end else begin
                            do_load = 1'b1;
                            state_d = ST_MC_STORE;
                        end
`else
                        // First element's load happens in this RUN cycle.
                        do_load = 1'b1;
                        state_d = ST_MC_STORE;
`endif
                    end
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
`endif
                    end
                endcase
            end
            ST_MC_LOAD: begin
                do_load = 1'b1;
                state_d = ST_MC_STORE;
            end
            ST_MC_STORE: begin
                do_store = 1'b1;
                state_d  = ex_no_stay ? ST_RUN : ST_MC_LOAD;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_HALT: begin
                stay = 1'b1;
            end
`endif
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (do_load) begin
            write_en      = 1'b1;
            mem_read      = 1'b1;
            alu_b_sel     = 1'b1;
            alu_sel       = `ALU_ADD;
            write_src_sel = `WSRC_MEM;
            stay          = 1'b1;
            counter_sel   = 1'b1;
        end
        if (do_store) begin
            mem_write    = 1'b1;
            alu_b_sel    = 1'b1;
            alu_sel      = `ALU_ADD;
            stay         = 1'b1;
            memcpy_store = 1'b1;
            counter_en   = 1'b1;
            counter_sel  = 1'b1;
        end
    end

    assign ctrl_c = {write_en, alu_sel, alu_b_sel, alu_a_sel, mem_write, mem_read,
                     ls_type, load_unsigned, write_src_sel, branch_type,
                     stay, memcpy_store, counter_en, counter_sel};

    // Reset forces a NOP bundle immediately, independent of the clock.
    assign ctrl_signals = rst ? '0 : ctrl_c;

    assign busy = !rst && ((state_q == ST_MC_LOAD) || (state_q == ST_MC_STORE) ||
                           ((state_q == ST_RUN) && (opcode == MC_OPCODE)));

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural model of the decode and MEMCPY sequencing.
`timescale 1ns/1ps

module tb_control_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        ex_no_stay;
    logic [20:0] ctrl_signals;
    logic        busy;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic        illegal;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    control_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .ex_no_stay   (ex_no_stay),
        .ctrl_signals (ctrl_signals),
        .busy         (busy)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal      (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 1'b0;

    localparam logic [3:0] A_ADD   = 4'h0;
    localparam logic [3:0] A_SUB   = 4'h8;
    localparam logic [3:0] A_PASSB = 4'hF;
    localparam logic [1:0] W_MEM   = 2'b01;
    localparam logic [1:0] W_PC    = 2'b10;
    localparam logic [2:0] B_JUMP  = 3'd7;
    localparam logic [6:0] MC_OP   = 7'b0001011;

    // Literal expectations worked out by hand from the field layout.
    localparam logic [20:0] X_ADD  = 21'h100000;
    localparam logic [20:0] X_LW   = 21'h109880;
    localparam logic [20:0] X_SB   = 21'h00A000;
    localparam logic [20:0] X_MCLD = 21'h109089;
    localparam logic [20:0] X_MCST = 21'h00A00F;
    localparam logic [20:0] X_ADDI = 21'h108000;
    localparam logic [20:0] X_JAL  = 21'h10C170;
    localparam logic [20:0] X_SRAI = 21'h1D8000;
    localparam logic [20:0] X_BNE  = 21'h080020;
    localparam logic [20:0] X_HALT = 21'h000008;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h00812283;
    localparam logic [31:0] I_SB   = 32'h00310223;
    localparam logic [31:0] I_MC3  = 32'h0030A20B;
    localparam logic [31:0] I_MC0  = 32'h0000820B;
    localparam logic [31:0] I_ADDI = 32'hFFF10093;
    localparam logic [31:0] I_JAL  = 32'h010000EF;
    localparam logic [31:0] I_SRAI = 32'h40315093;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic [2:0] br_tab [8] = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [20:0] pack(input logic we, input logic [3:0] alu, input logic bs,
                                         input logic as, input logic mw, input logic mr,
                                         input logic [1:0] ls, input logic un, input logic [1:0] ws,
                                         input logic [2:0] br, input logic st, input logic ms,
                                         input logic ce, input logic cs);
        return {we, alu, bs, as, mw, mr, ls, un, ws, br, st, ms, ce, cs};
    endfunction

    function automatic bit known_op(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, MC_OP};
    endfunction

    function automatic bit mc_bad(input logic [31:0] ins);
        return TRAP && !(ins[14:12] inside {3'b000, 3'b010});
    endfunction

    // Single-cycle decode rules for ordinary instructions.
    function automatic logic [20:0] model_run(input logic [31:0] ins);
        logic [2:0] f3;
        logic       f7b;
        f3  = ins[14:12];
        f7b = ins[30];
        case (ins[6:0])
            7'h33: return pack(1'b1, {f7b, f3}, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            7'h13: return pack(1'b1, (f3 == 3'b101) ? {f7b, f3} : {1'b0, f3}, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            7'h03: return pack(1'b1, A_ADD, 1'b1, 1'b0, 1'b0, 1'b1, f3[1:0], f3[2], W_MEM, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            7'h23: return pack(1'b0, A_ADD, 1'b1, 1'b0, 1'b1, 1'b0, f3[1:0], 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            7'h63: return pack(1'b0, A_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, br_tab[f3], 1'b0, 1'b0, 1'b0, 1'b0);
            7'h6F: return pack(1'b1, A_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, W_PC, B_JUMP, 1'b0, 1'b0, 1'b0, 1'b0);
            7'h67: return pack(1'b1, A_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, W_PC, B_JUMP, 1'b0, 1'b0, 1'b0, 1'b0);
            7'h37: return pack(1'b1, A_PASSB, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            7'h17: return pack(1'b1, A_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            default: return 21'h0;
        endcase
    endfunction

    // Model state: cycles already spent in the current MEMCPY (even = load, odd = store).
    int mc_cycles = 0;
    bit halted    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_cycles <= 0;
            halted    <= 1'b0;
        end else if (!halted) begin
            if (mc_cycles == 0) begin
                if (instruction[6:0] == MC_OP) begin
                    if (mc_bad(instruction)) halted <= 1'b1;
                    else                     mc_cycles <= 1;
                end else if (TRAP && !known_op(instruction[6:0])) begin
                    halted <= 1'b1;
                end
            end else if (mc_cycles % 2 == 1) begin
                mc_cycles <= ex_no_stay ? 0 : mc_cycles + 1;
            end else begin
                mc_cycles <= mc_cycles + 1;
            end
        end
    end

    function automatic logic [20:0] model_ctrl();
        logic [20:0] ld, st;
        ld = pack(1'b1, A_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, W_MEM, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        st = pack(1'b0, A_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        if (rst)                   return 21'h0;
        if (halted)                return pack(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        if (mc_cycles % 2 == 1)    return st;
        if (mc_cycles > 0)         return ld;
        if (instruction[6:0] == MC_OP) return mc_bad(instruction) ? 21'h0 : ld;
        return model_run(instruction);
    endfunction

    function automatic logic model_busy();
        if (rst || halted) return 1'b0;
        return (mc_cycles > 0) || (instruction[6:0] == MC_OP);
    endfunction

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!done) begin
            check("model_ctrl", 32'(ctrl_signals), 32'(model_ctrl()));
            check("model_busy", 32'(busy), 32'(model_busy()));
`ifdef CTRL_ILLEGAL_TRAP_EN
            check("model_illegal", 32'(illegal), 32'(halted));
`endif
        end
    end

    task automatic next(input logic [31:0] ins, input logic ens);
        @(posedge clk);
        #1;
        instruction = ins;
        ex_no_stay  = ens;
        @(negedge clk);
    endtask

    logic [31:0] vec [14] = '{32'h403100B3, 32'h403150B3, 32'h003160B3, 32'h00513093,
                              32'h00014083, 32'h00011083, 32'h00312023, 32'h00208463,
                              32'h0020F463, 32'h0020A463, 32'h000100E7, 32'h123450B7,
                              32'h12345097, 32'h00A00113};

    initial begin
        rst = 1'b1;
        instruction = I_ADD;
        ex_no_stay = 1'b0;
        @(negedge clk);
        check("rst_ctrl", 32'(ctrl_signals), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        #1 rst = 1'b0;

        next(I_ADD, 1'b0);
        check("add_ctrl", 32'(ctrl_signals), 32'(X_ADD));
        check("add_busy", 32'(busy), 32'h0);
        next(I_LW, 1'b0);
        check("lw_ctrl", 32'(ctrl_signals), 32'(X_LW));
        next(I_SB, 1'b0);
        check("sb_ctrl", 32'(ctrl_signals), 32'(X_SB));

        // MEMCPY N=3: L S L S L S, done pulsed in the third store.
        for (int c = 0; c < 6; c++) begin
            next(I_MC3, c == 5);
            check("mc3_ctrl", 32'(ctrl_signals), 32'((c % 2 == 0) ? X_MCLD : X_MCST));
            check("mc3_busy", 32'(busy), 32'h1);
        end
        next(I_ADD, 1'b0);
        check("mc3_after", 32'(ctrl_signals), 32'(X_ADD));
        check("mc3_after_busy", 32'(busy), 32'h0);

        // MEMCPY N=0: one load/store pair, then the following instruction decodes.
        next(I_MC0, 1'b0);
        check("mc0_load", 32'(ctrl_signals), 32'(X_MCLD));
        next(I_MC0, 1'b1);
        check("mc0_store", 32'(ctrl_signals), 32'(X_MCST));
        next(I_ADDI, 1'b0);
        check("mc0_after_addi", 32'(ctrl_signals), 32'(X_ADDI));

        // ex_no_stay outside a store must not end the copy.
        next(I_MC3, 1'b1);
        next(I_MC3, 1'b0);
        next(I_MC3, 1'b1);
        check("ens_ignored_load", 32'(ctrl_signals), 32'(X_MCLD));
        next(I_MC3, 1'b1);
        next(I_ADD, 1'b0);
        check("ens_done_add", 32'(ctrl_signals), 32'(X_ADD));

        // Asynchronous reset while in a load phase.
        next(I_MC3, 1'b0);
        next(I_MC3, 1'b0);
        next(I_MC3, 1'b0);
        check("pre_rst_load", 32'(ctrl_signals), 32'(X_MCLD));
        #2 rst = 1'b1;
        #1;
        check("async_rst_ctrl", 32'(ctrl_signals), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        instruction = I_ADD;
        @(negedge clk);
        check("post_rst_run", 32'(ctrl_signals), 32'(X_ADD));

        next(I_JAL, 1'b0);
        check("jal_ctrl", 32'(ctrl_signals), 32'(X_JAL));
        next(I_SRAI, 1'b0);
        check("srai_ctrl", 32'(ctrl_signals), 32'(X_SRAI));
        next(I_BNE, 1'b0);
        check("bne_ctrl", 32'(ctrl_signals), 32'(X_BNE));
        for (int i = 0; i < 14; i++) next(vec[i], 1'b0);

`ifdef CTRL_ILLEGAL_TRAP_EN
        next(I_BAD, 1'b0);
        check("ill_run_ctrl", 32'(ctrl_signals), 32'h0);
        check("ill_flag_pre", 32'(illegal), 32'h0);
        for (int i = 0; i < 10; i++) begin
            next((i % 2 == 0) ? I_ADD : I_MC3, 1'b0);
            check("halt_ctrl", 32'(ctrl_signals), 32'(X_HALT));
            check("halt_illegal", 32'(illegal), 32'h1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        instruction = I_ADD;
        @(negedge clk);
        check("halt_exit_rst", 32'(ctrl_signals), 32'(X_ADD));
`else
        next(I_BAD, 1'b0);
        check("bad_nop_ctrl", 32'(ctrl_signals), 32'h0);
        check("bad_nop_busy", 32'(busy), 32'h0);
        next(I_ADD, 1'b0);
        check("bad_then_add", 32'(ctrl_signals), 32'(X_ADD));
`endif

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
